// File: rtl/apu_sweep_if.sv
// Ready/valid bundle between the APU register interface, the sweep unit and the pulse channel.
interface apu_sweep_if;
    logic [10:0] period_r;
    logic        period_r_vld;
    logic        period_r_rdy;
    logic [7:0]  cfg_r;
    logic        cfg_r_vld;
    logic        cfg_r_rdy;
    logic        tick;
    logic [10:0] period_s;
    logic        period_s_vld;
    logic        period_s_rdy;
    logic        mute;

    modport slave (
        input  period_r, period_r_vld, cfg_r, cfg_r_vld, tick, period_s_rdy,
        output period_r_rdy, cfg_r_rdy, period_s, period_s_vld, mute
    );

    modport master (
        output period_r, period_r_vld, cfg_r, cfg_r_vld, tick, period_s_rdy,
        input  period_r_rdy, cfg_r_rdy, period_s, period_s_vld, mute
    );
endinterface

// File: rtl/apu_sweep.sv
// APU frequency sweep: holds the pulse period, moves it on half-frame ticks and
// forwards every new period through a single-entry latest-wins output buffer.
module apu_sweep #(
    parameter bit ONES_COMPLEMENT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    apu_sweep_if.slave  sweep
);

    logic [10:0] period_q, period_d;
    logic [7:0]  cfg_q, cfg_d;
    logic [2:0]  divider_q, divider_d;
    logic        reload_q, reload_d;
    logic [10:0] out_data_q, out_data_d;
    logic        out_vld_q, out_vld_d;

    logic        cfg_enable_s;
    logic [2:0]  cfg_div_p_s;
    logic        cfg_negate_s;
    logic [2:0]  cfg_shift_s;
    logic [10:0] delta_s;
    logic [11:0] sum_s;
    logic [11:0] diff_s;
    logic [11:0] target_s;
    logic        mute_s;
    logic        update_s;

    assign cfg_enable_s = cfg_q[7];
    assign cfg_div_p_s  = cfg_q[6:4];
    assign cfg_negate_s = cfg_q[3];
    assign cfg_shift_s  = cfg_q[2:0];

    // Sweep target; a borrow out of the subtraction clamps the result to zero.
    always_comb begin
        delta_s  = period_q >> cfg_shift_s;
        sum_s    = {1'b0, period_q} + {1'b0, delta_s};
        diff_s   = {1'b0, period_q} - {1'b0, delta_s} - {11'd0, ONES_COMPLEMENT};
        target_s = 12'd0;
        if (cfg_negate_s) begin
            if (diff_s[11]) begin
                target_s = 12'd0;
            end else begin
                target_s = diff_s;
            end
        end else begin
            target_s = sum_s;
        end
    end

    assign mute_s   = (period_q < 11'd8) | (target_s[11] & ~cfg_negate_s);
    assign update_s = sweep.tick & (divider_q == 3'd0) & cfg_enable_s
                      & (cfg_shift_s != 3'd0) & ~mute_s;

    // Next state: a load overrides a sweep update, a config write overrides the reload clear.
    always_comb begin
        period_d   = period_q;
        cfg_d      = cfg_q;
        divider_d  = divider_q;
        reload_d   = reload_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;

        if (out_vld_q && sweep.period_s_rdy) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end

        if (sweep.period_r_vld) begin
            period_d   = sweep.period_r;
            out_data_d = sweep.period_r;
            out_vld_d  = 1'b1;
        end else if (update_s) begin
            period_d   = target_s[10:0];
            out_data_d = target_s[10:0];
            out_vld_d  = 1'b1;
        end else begin
            period_d   = period_q;
        end

        if (sweep.tick) begin
            if ((divider_q == 3'd0) || reload_q) begin
                divider_d = cfg_div_p_s;
                reload_d  = 1'b0;
            end else begin
                divider_d = divider_q - 3'd1;
            end
        end else begin
            divider_d = divider_q;
        end

        if (sweep.cfg_r_vld) begin
            cfg_d    = sweep.cfg_r;
            reload_d = 1'b1;
        end else begin
            cfg_d    = cfg_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q   <= 11'd0;
            cfg_q      <= 8'd0;
            divider_q  <= 3'd0;
            reload_q   <= 1'b0;
            out_data_q <= 11'd0;
            out_vld_q  <= 1'b0;
        end else begin
            period_q   <= period_d;
            cfg_q      <= cfg_d;
            divider_q  <= divider_d;
            reload_q   <= reload_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign sweep.period_r_rdy = 1'b1;
    assign sweep.cfg_r_rdy    = 1'b1;
    assign sweep.period_s     = out_data_q;
    assign sweep.period_s_vld = out_vld_q;
    assign sweep.mute         = mute_s;

endmodule
